// File: rtl/wb_lfsr_master.sv
// Pipelined Wishbone initiator for the narrow LFSR bus: single writes or 1..8-beat bit reads packed into a byte.
// Optional per-beat ack timeout is compiled in with WB_MASTER_TIMEOUT_EN.
module wb_lfsr_master #(
    parameter int ADDR_W         = 3,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [2:0]        cmd_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic [DATA_W-1:0] o_wb_data,
    input  logic              i_wb_stall,
    input  logic              i_wb_data,
    input  logic              i_wb_ack
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state;
    state_t            state_next;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [2:0]        len_q;
    logic [2:0]        beat;
    logic              last_beat;
    logic              timeout_hit;

    assign last_beat = we_q || (beat == len_q);
    assign rsp_data  = rdata_q;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer;
    logic          err_q;

    // An ack arriving in the expiry cycle completes the beat instead of aborting.
    assign timeout_hit = (state == REQ || state == WAIT) && (timer == '0)
                         && !(state == WAIT && i_wb_ack);
    assign rsp_err     = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_next == REQ && state != REQ)
                timer <= TW'(TIMEOUT_CYCLES - 1);
            else if ((state == REQ || state == WAIT) && timer != '0)
                timer <= timer - 1'b1;

            if (state == IDLE && cmd_valid)
                err_q <= 1'b0;
            else if (timeout_hit)
                err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cmd_valid) state_next = REQ;
            REQ: begin
                if (timeout_hit)
                    state_next = RESP;
                else if (!i_wb_stall)
                    state_next = WAIT;
            end
            WAIT: begin
                if (i_wb_ack)
                    state_next = last_beat ? RESP : REQ;
                else if (timeout_hit)
                    state_next = RESP;
            end
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        o_wb_cyc  = 1'b0;
        o_wb_stb  = 1'b0;
        o_wb_we   = 1'b0;
        o_wb_addr = '0;
        o_wb_data = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            REQ: begin
                o_wb_cyc  = 1'b1;
                o_wb_stb  = 1'b1;
                o_wb_we   = we_q;
                o_wb_addr = addr_q;
                o_wb_data = wdata_q;
            end
            WAIT: begin
                o_wb_cyc  = 1'b1;
                o_wb_we   = we_q;
                o_wb_addr = addr_q;
                o_wb_data = wdata_q;
            end
            RESP: rsp_valid = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            len_q   <= '0;
            beat    <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                we_q    <= cmd_we;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                len_q   <= cmd_len;
                beat    <= '0;
                rdata_q <= '0;
            end
            // Beat index doubles as the bit position; beat 0 lands in the LSB.
            if (state == WAIT && i_wb_ack) begin
                if (!we_q)
                    rdata_q[beat] <= i_wb_data;
                if (!last_beat)
                    beat <= beat + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_lfsr_master.sv
// Scoreboard bench for wb_lfsr_master: directed commands, Wishbone responder model, response monitor.
module tb_wb_lfsr_master;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [2:0] cmd_len;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic       o_wb_cyc;
    logic       o_wb_stb;
    logic       o_wb_we;
    logic [2:0] o_wb_addr;
    logic [7:0] o_wb_data;
    logic       i_wb_stall;
    logic       i_wb_data;
    logic       i_wb_ack;

    wb_lfsr_master #(.ADDR_W(3), .DATA_W(8), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data), .i_wb_ack(i_wb_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_pushed = 0;
    int   n_rsp = 0;

    // responder configuration and observations
    int         stall_left = 0;
    logic       stray = 1'b0;
    int         ack_limit = 0;
    int         ack_count = 0;
    logic [7:0] ack_bits = 8'h00;
    logic       exp_we = 1'b0;
    logic [2:0] exp_addr = 3'd0;
    logic [7:0] exp_data = 8'h00;
    int         stb_cycles = 0;
    int         stb_acc = 0;
    int         bus_bad = 0;

    // monitor observations
    int   n_cyc = 0;
    int   accept_n = 0;
    int   lat = 0;
    int   stb_rise_n = 0;
    int   stb_rises = 0;
    int   drop_n = 0;
    int   gap_cnt = 0;
    logic prev_stb = 1'b0;
    logic prev_cyc = 1'b0;
    logic prev_rsp_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        i_wb_ack   = 1'b0;
        i_wb_stall = 1'b0;
        i_wb_data  = 1'b0;
        if (rst_n) begin
            if (o_wb_cyc && (o_wb_addr !== exp_addr || o_wb_we !== exp_we ||
                             (exp_we && o_wb_data !== exp_data)))
                bus_bad++;
            if (o_wb_stb) begin
                stb_cycles++;
                if (stall_left > 0) begin
                    i_wb_stall = 1'b1;
                    stall_left--;
                    if (stray) begin
                        i_wb_ack  = 1'b1;
                        i_wb_data = 1'b1;
                    end
                end else begin
                    stb_acc++;
                end
            end else if (o_wb_cyc && ack_count < ack_limit) begin
                i_wb_ack  = 1'b1;
                i_wb_data = ack_bits[ack_count];
                ack_count++;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        n_cyc++;
        if (rst_n) begin
            if (cmd_valid && cmd_ready) accept_n = n_cyc;
            if (rsp_valid && !prev_rsp_valid) lat = n_cyc - accept_n;
            if (o_wb_stb && !prev_stb) begin
                stb_rise_n = n_cyc;
                stb_rises++;
            end
            if (prev_cyc && !o_wb_cyc && busy) drop_n = n_cyc;
            if (busy && !rsp_valid && !o_wb_cyc) gap_cnt++;
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got data=%0h err=%0b with none expected", rsp_data, rsp_err);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                end
            end
        end
        prev_stb       = o_wb_stb;
        prev_cyc       = o_wb_cyc;
        prev_rsp_valid = rsp_valid;
    end

    task automatic push_exp(input logic [7:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        exp_q.push_back(x);
        n_pushed++;
    endtask

    task automatic prep(input int stall, input logic st, input int limit, input logic [7:0] bits,
                        input logic we, input logic [2:0] addr, input logic [7:0] data);
        stall_left = stall;
        stray      = st;
        ack_limit  = limit;
        ack_count  = 0;
        ack_bits   = bits;
        exp_we     = we;
        exp_addr   = addr;
        exp_data   = data;
        stb_cycles = 0;
        stb_acc    = 0;
        bus_bad    = 0;
        gap_cnt    = 0;
        stb_rises  = 0;
    endtask

    task automatic send_cmd(input logic we, input logic [2:0] addr, input logic [7:0] wdata,
                            input logic [2:0] len);
        int n;
        @(negedge clk);
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_len   = len;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("cmd_accept_timeout", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int   n;
        int   rsp_before;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = 3'd0;
        cmd_wdata = 8'h00;
        cmd_len   = 3'd0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cyc_stb", {30'd0, o_wb_cyc, o_wb_stb}, 32'd0);
        check("rst_wb_fields", {20'd0, o_wb_we, o_wb_addr, o_wb_data}, 32'd0);
        check("rst_rsp", {22'd0, rsp_valid, rsp_err, rsp_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single write
        prep(0, 1'b0, 1, 8'h00, 1'b1, 3'd1, 8'hA5);
        push_exp(8'h00, 1'b0);
        send_cmd(1'b1, 3'd1, 8'hA5, 3'd5);
        wait_idle("wr_done_timeout");
        check("wr_stb_cycles", stb_cycles, 32'd1);
        check("wr_bus_fields", bus_bad, 32'd0);
        check("wr_latency", lat, 32'd3);

        // 8-beat read, bits 1,0,1,1,0,0,1,0
        prep(0, 1'b0, 8, 8'b0100_1101, 1'b0, 3'd2, 8'h00);
        push_exp(8'h4D, 1'b0);
        send_cmd(1'b0, 3'd2, 8'h00, 3'd7);
        wait_idle("rd8_done_timeout");
        check("rd8_stb_pulses", stb_rises, 32'd8);
        check("rd8_stb_acc", stb_acc, 32'd8);
        check("rd8_cyc_gap", gap_cnt, 32'd0);
        check("rd8_bus_fields", bus_bad, 32'd0);

        // 3-beat read, bits 0,1,1; upper bits must read 0
        prep(0, 1'b0, 3, 8'b1111_1110, 1'b0, 3'd7, 8'h00);
        push_exp(8'h06, 1'b0);
        send_cmd(1'b0, 3'd7, 8'h00, 3'd2);
        wait_idle("rd3_done_timeout");
        check("rd3_stb_acc", stb_acc, 32'd3);

        // stalled single read
        prep(3, 1'b0, 1, 8'h01, 1'b0, 3'd4, 8'h00);
        push_exp(8'h01, 1'b0);
        send_cmd(1'b0, 3'd4, 8'h00, 3'd0);
        wait_idle("stall_done_timeout");
        check("stall_stb_cycles", stb_cycles, 32'd4);
        check("stall_stb_pulses", stb_rises, 32'd1);
        check("stall_bus_fields", bus_bad, 32'd0);

        // acks while stalled (nothing outstanding) carry bit 1 and must be ignored
        prep(2, 1'b1, 1, 8'h00, 1'b0, 3'd5, 8'h00);
        push_exp(8'h00, 1'b0);
        send_cmd(1'b0, 3'd5, 8'h00, 3'd0);
        wait_idle("stray_done_timeout");
        check("stray_stb_cycles", stb_cycles, 32'd3);

`ifdef WB_MASTER_TIMEOUT_EN
        prep(0, 1'b0, 1, 8'h01, 1'b0, 3'd3, 8'h00);
        push_exp(8'h01, 1'b1);
        send_cmd(1'b0, 3'd3, 8'h00, 3'd3);
        wait_idle("tmo_done_timeout");
        check("tmo_drop_delay", drop_n - stb_rise_n, 32'd15);
        check("tmo_stb_acc", stb_acc, 32'd2);
`endif

        // reset during beat 2 of a 4-beat read
        prep(0, 1'b0, 4, 8'hFF, 1'b0, 3'd6, 8'h00);
        rsp_before = n_rsp;
        send_cmd(1'b0, 3'd6, 8'h00, 3'd3);
        n = 0;
        while (!(o_wb_stb && stb_rises == 2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reach_beat2", {31'd0, o_wb_stb}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_cyc_stb", {30'd0, o_wb_cyc, o_wb_stb}, 32'd0);
        check("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (5) @(negedge clk);
        check("rst_mid_no_rsp", n_rsp, rsp_before);
        ack_limit = 0;

        // response held off by rsp_ready; next command must wait
        prep(0, 1'b0, 2, 8'h03, 1'b0, 3'd3, 8'h00);
        rsp_ready = 1'b0;
        push_exp(8'h03, 1'b0);
        send_cmd(1'b0, 3'd3, 8'h00, 3'd1);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("hold_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        prep(0, 1'b0, 1, 8'h00, 1'b1, 3'd4, 8'h3C);
        cmd_we    = 1'b1;
        cmd_addr  = 3'd4;
        cmd_wdata = 8'h3C;
        cmd_len   = 3'd0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rsp_data", {24'd0, rsp_data}, 32'h03);
            check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        push_exp(8'h00, 1'b0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hold_release_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle("hold_wr_timeout");
        check("hold_wr_stb_acc", stb_acc, 32'd1);
        check("hold_wr_bus_fields", bus_bad, 32'd0);

        repeat (3) @(negedge clk);
        check("sb_leftover", exp_q.size(), 32'd0);
        check("rsp_count", n_rsp, n_pushed);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
